// File: rtl/reg_move_pkg.sv
// Shared definitions for the register-move sequencer: opcodes, register
// indices, FSM encodings, queued command layout and a one-hot decoder.
package reg_move_pkg;

  localparam logic [1:0] OP_MOVE = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;

  localparam int unsigned R      = 0;
  localparam int unsigned row    = 1;
  localparam int unsigned cAT    = 2;
  localparam int unsigned cB     = 3;
  localparam int unsigned rnow   = 4;
  localparam int unsigned cATnow = 5;
  localparam int unsigned cBnow  = 6;
  localparam int unsigned alphap = 7;
  localparam int unsigned betap  = 8;
  localparam int unsigned gammap = 9;
  localparam int unsigned Total  = 10;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  localparam int unsigned ONEHOT_W = 16;

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] src;
    logic [3:0] dst;
  } cmd_t;

  function automatic logic [ONEHOT_W-1:0] onehot(input logic [3:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/reg_move_sequencer_cmd_fifo.sv
// Show-ahead synchronous command FIFO with occupancy count and async
// active-low reset; rdata always presents the head entry.
module cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/reg_move_sequencer.sv
// Queued MOVE/INC/CLR micro-command executor driving the register file's
// one-hot read/write strobes and its bus data input.
module reg_move_sequencer
  import reg_move_pkg::*;
#(
  parameter int unsigned REG_COUNT  = 11,
  parameter int unsigned REG_WIDTH  = 12,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [3:0]           cmd_src,
  input  logic [3:0]           cmd_dst,
  input  logic [REG_WIDTH-1:0] rf_dataout,
  output logic [REG_COUNT-1:0] read_en,
  output logic [REG_COUNT-1:0] write_en,
  output logic [REG_WIDTH-1:0] bus_data,
  output logic                 busy,
  output logic                 err
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [4:0]  RC = 5'(REG_COUNT);

  cmd_t           wr_cmd;
  cmd_t           head;
  logic           full;
  logic           empty;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_n;
  logic           push;
  logic           pop;
  logic           illegal;
  logic [1:0]     state;
  logic [1:0]     state_n;
  logic [3:0]     cur_dst;
  logic           cur_inc;
  logic [REG_WIDTH-1:0] rd_val;

  assign wr_cmd    = '{op: cmd_op, src: cmd_src, dst: cmd_dst};
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && !empty;
  assign count_n   = count + CW'(push) - CW'(pop);
  assign rd_val    = cur_inc ? rf_dataout + REG_WIDTH'(1'b1) : rf_dataout;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wr_cmd),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    illegal = (head.op == 2'b11) || ({1'b0, head.dst} >= RC) ||
              ((head.op != OP_CLR) && ({1'b0, head.src} >= RC));
    state_n = state;
    case (state)
      IDLE:    if (!empty && !illegal) state_n = (head.op == OP_CLR) ? WRITE : READ;
      READ:    state_n = WRITE;
      WRITE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // bus_data doubles as the hold register: it is loaded on entry to WRITE and
  // keeps its value afterwards, so no separate hold flop is needed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      read_en  <= '0;
      write_en <= '0;
      bus_data <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
      cur_dst  <= '0;
      cur_inc  <= 1'b0;
    end else begin
      state    <= state_n;
      busy     <= (state_n != IDLE) || (count_n != '0);
      err      <= 1'b0;
      read_en  <= '0;
      write_en <= '0;
      case (state)
        IDLE: begin
          if (!empty) begin
            if (illegal) begin
              err <= 1'b1;
            end else begin
              cur_dst <= head.dst;
              cur_inc <= (head.op == OP_INC);
              if (head.op == OP_CLR) begin
                write_en <= REG_COUNT'(onehot(head.dst));
                bus_data <= '0;
              end else begin
                read_en <= REG_COUNT'(onehot(head.src));
              end
            end
          end
        end
        READ: begin
          write_en <= REG_COUNT'(onehot(cur_dst));
          bus_data <= rd_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_move_sequencer.sv
// Self-checking bench: a queue-based command model plus a register file
// model, compared against the sequencer every cycle.
module tb_reg_move_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = '0;
  logic [3:0]  cmd_src = '0;
  logic [3:0]  cmd_dst = '0;
  logic        cmd_ready;
  logic [11:0] rf_dataout;
  logic [10:0] read_en;
  logic [10:0] write_en;
  logic [11:0] bus_data;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  reg_move_sequencer #(.REG_COUNT(11), .REG_WIDTH(12), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .rf_dataout(rf_dataout),
    .read_en(read_en), .write_en(write_en), .bus_data(bus_data), .busy(busy), .err(err)
  );

  // environment register file, written only by DUT strobes or bench preloads
  logic [11:0] env_rf [11];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_idx = '0;
  logic [11:0] pre_val = '0;

  always_comb begin
    rf_dataout = '0;
    for (int i = 0; i < 11; i++) if (read_en[i]) rf_dataout = env_rf[i];
  end

  always @(posedge clk) begin
    if (pre_we) env_rf[pre_idx] <= pre_val;
    for (int i = 0; i < 11; i++) if (write_en[i]) env_rf[i] <= bus_data;
  end

  // reference model: pending command queue, engine phase, expected registers
  typedef struct { logic [1:0] op; int unsigned src; int unsigned dst; } mcmd_t;
  mcmd_t       q[$];
  mcmd_t       cur;
  int          phase = 0;   // 0 waiting, 1 reading source, 2 writing destination
  logic [11:0] hold = '0;
  logic        exp_err = 1'b0;
  logic [11:0] mdl_rf [11];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [36:0] got;

  assign got = {read_en, write_en, bus_data, busy, err, cmd_ready};

  function automatic bit is_illegal(input mcmd_t c);
    return (c.op == 2'b11) || (c.dst >= 11) || (c.op != 2'b10 && c.src >= 11);
  endfunction

  function automatic void model_step();
    mcmd_t c;
    bit    acc;
    if (!reset) begin
      q.delete(); phase = 0; hold = '0; exp_err = 1'b0;
      return;
    end
    acc = cmd_valid && (q.size() < 4);
    exp_err = 1'b0;
    case (phase)
      0: if (q.size() > 0) begin
        c = q.pop_front();
        if (is_illegal(c)) exp_err = 1'b1;
        else begin
          cur = c;
          if (c.op == 2'b10) begin hold = '0; phase = 2; end
          else phase = 1;
        end
      end
      1: begin hold = mdl_rf[cur.src] + ((cur.op == 2'b01) ? 12'd1 : 12'd0); phase = 2; end
      default: begin mdl_rf[cur.dst] = hold; phase = 0; end
    endcase
    if (acc) begin
      c.op = cmd_op; c.src = cmd_src; c.dst = cmd_dst;
      q.push_back(c);
    end
  endfunction

  function automatic logic [36:0] exp_vec();
    logic [10:0] rd;
    logic [10:0] wr;
    rd = '0; wr = '0;
    if (phase == 1) rd[cur.src] = 1'b1;
    if (phase == 2) wr[cur.dst] = 1'b1;
    return {rd, wr, hold, (phase != 0 || q.size() != 0), exp_err, (q.size() < 4)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] s, input logic [3:0] d);
    cmd_valid = v; cmd_op = op; cmd_src = s; cmd_dst = d;
  endtask

  task automatic preload(input int unsigned idx, input logic [11:0] val);
    pre_we = 1'b1; pre_idx = 4'(idx); pre_val = val;
    tick();
    pre_we = 1'b0;
    mdl_rf[idx] = val;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    for (int i = 0; i < 11; i++) preload(i, 12'($urandom));
    checks++;
    if ({read_en, write_en, bus_data, busy, err} !== 36'd0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", {read_en, write_en, bus_data, busy, err});
    end
    reset = 1'b1;
    tick();
    checks++;
    if (got !== exp_vec()) begin
      errors++; $display("FAIL reset_release cyc=%0d got=%h exp=%h", cyc, got, exp_vec());
    end
  endtask

  task automatic test_move();
    preload(8, 12'd900);
    drive(1'b1, 2'b00, 4'd8, 4'd0);
    tick();
    drive(1'b0, 2'b00, 4'd0, 4'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (got !== exp_vec()) begin
        errors++; $display("FAIL move cyc=%0d got=%h exp=%h", cyc, got, exp_vec());
      end
    end
    checks++;
    if (env_rf[0] !== 12'd900) begin
      errors++; $display("FAIL move_result got=%0d exp=900", env_rf[0]);
    end
  endtask

  task automatic test_inc();
    logic [11:0] start [2];
    start[0] = 12'd4095; start[1] = 12'd5;
    for (int k = 0; k < 2; k++) begin
      preload(10, start[k]);
      drive(1'b1, 2'b01, 4'd10, 4'd10);
      tick();
      drive(1'b0, 2'b00, 4'd0, 4'd0);
      for (int i = 0; i < 5; i++) begin
        tick();
        checks++;
        if (got !== exp_vec()) begin
          errors++; $display("FAIL inc cyc=%0d got=%h exp=%h", cyc, got, exp_vec());
        end
      end
      checks++;
      if (env_rf[10] !== start[k] + 12'd1) begin
        errors++; $display("FAIL inc_result got=%0d exp=%0d", env_rf[10], start[k] + 12'd1);
      end
    end
  endtask

  task automatic test_clr();
    preload(3, 12'h5a5);
    drive(1'b1, 2'b10, 4'($urandom_range(0, 15)), 4'd3);
    tick();
    drive(1'b0, 2'b00, 4'd0, 4'd0);
    tick();
    checks++;
    if (read_en !== 11'd0 || write_en !== 11'h008 || bus_data !== 12'd0) begin
      errors++; $display("FAIL clr_latency rd=%h wr=%h bus=%h exp rd=0 wr=008 bus=0", read_en, write_en, bus_data);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (got !== exp_vec()) begin
        errors++; $display("FAIL clr cyc=%0d got=%h exp=%h", cyc, got, exp_vec());
      end
    end
    checks++;
    if (env_rf[3] !== 12'd0) begin
      errors++; $display("FAIL clr_result got=%0d exp=0", env_rf[3]);
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int wcyc[$];
    bit saw_full = 1'b0;
    bit acc;
    for (int n = 0; n < 80 && (sent < 7 || phase != 0 || q.size() != 0); n++) begin
      if (sent < 7) drive(1'b1, 2'b00, 4'($urandom_range(0, 10)), 4'($urandom_range(0, 10)));
      else drive(1'b0, 2'b00, 4'd0, 4'd0);
      acc = (sent < 7) && (q.size() < 4);
      tick();
      if (acc) sent++;
      if (write_en != 0) wcyc.push_back(cyc);
      if (cmd_ready === 1'b0) saw_full = 1'b1;
      checks++;
      if (got !== exp_vec()) begin
        errors++; $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, got, exp_vec());
      end
    end
    drive(1'b0, 2'b00, 4'd0, 4'd0);
    checks++;
    if (wcyc.size() != 7 || !saw_full) begin
      errors++; $display("FAIL b2b_count writes=%0d full_seen=%0d exp writes=7 full_seen=1", wcyc.size(), saw_full);
    end
    for (int i = 1; i < wcyc.size(); i++) begin
      checks++;
      if (wcyc[i] - wcyc[i-1] != 3) begin
        errors++; $display("FAIL b2b_spacing gap=%0d exp=3", wcyc[i] - wcyc[i-1]);
      end
    end
  endtask

  task automatic test_illegal();
    int errs = 0;
    logic [11:0] v;
    v = 12'($urandom);
    preload(4, v);
    drive(1'b1, 2'b11, 4'd1, 4'd2);  tick();
    drive(1'b1, 2'b00, 4'd2, 4'd11); tick(); if (err) errs++;
    drive(1'b1, 2'b00, 4'd15, 4'd1); tick(); if (err) errs++;
    drive(1'b1, 2'b00, 4'd4, 4'd5);  tick(); if (err) errs++;
    drive(1'b0, 2'b00, 4'd0, 4'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (err) errs++;
      checks++;
      if (got !== exp_vec()) begin
        errors++; $display("FAIL illegal cyc=%0d got=%h exp=%h", cyc, got, exp_vec());
      end
    end
    checks++;
    if (errs != 3 || env_rf[5] !== v) begin
      errors++; $display("FAIL illegal_summary err_pulses=%0d r5=%h exp err_pulses=3 r5=%h", errs, env_rf[5], v);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 12)), 4'($urandom_range(0, 12)));
      tick();
      checks++;
      if (got !== exp_vec()) begin
        errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, got, exp_vec());
      end
    end
    drive(1'b0, 2'b00, 4'd0, 4'd0);
    for (int i = 0; i < 40 && (phase != 0 || q.size() != 0); i++) tick();
    checks++;
    if (phase != 0 || q.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL random_drain busy=%0d exp=0", busy);
    end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (env_rf[i] !== mdl_rf[i]) begin
        errors++; $display("FAIL random_rf idx=%0d got=%h exp=%h", i, env_rf[i], mdl_rf[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    bit wr_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b00, 4'($urandom_range(0, 10)), 4'($urandom_range(0, 10)));
      tick();
    end
    drive(1'b0, 2'b00, 4'd0, 4'd0);
    for (int i = 0; i < 10 && !found; i++) begin
      if (phase == 1 && q.size() == 2) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found || read_en === 11'd0) begin
      errors++; $display("FAIL reset_mid_setup read_en=%h exp=nonzero in READ", read_en);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({read_en, write_en, bus_data, busy, err} !== 36'd0) begin
      errors++; $display("FAIL reset_mid_async got=%h exp=0", {read_en, write_en, bus_data, busy, err});
    end
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (write_en !== 11'd0) wr_seen = 1'b1;
      checks++;
      if (got !== exp_vec()) begin
        errors++; $display("FAIL reset_mid cyc=%0d got=%h exp=%h", cyc, got, exp_vec());
      end
    end
    checks++;
    if (wr_seen || busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_abort write_seen=%0d busy=%0d exp 0 0", wr_seen, busy);
    end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (env_rf[i] !== mdl_rf[i]) begin
        errors++; $display("FAIL reset_mid_rf idx=%0d got=%h exp=%h", i, env_rf[i], mdl_rf[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_move();
    test_inc();
    test_clr();
    test_back_to_back();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d exp=finished", cyc);
    $fatal(1);
  end

endmodule
